mem_port_arbiter: RTL

//  Shares the single-port 512x16 data/instruction RAM between the cpu memory interface
//  (mem_cmd/mem_addr) and a loader/debug port. The loader preloads programs and inspects results.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_arb_wait_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-port definitions: command encodings, RAM geometry and read-owner tags.
package mem_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LD
  } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, loader and RAM signal bundle around the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);
  logic [1:0]        cpu_mem_cmd;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Arbiter side.
  modport slave (
    input  cpu_mem_cmd, cpu_mem_addr, cpu_wdata,
    output cpu_read_data, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output ram_addr, ram_write, ram_din,
    input  ram_dout
  );

  // Requester / RAM side.
  modport master (
    output cpu_mem_cmd, cpu_mem_addr, cpu_wdata,
    input  cpu_read_data, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  ram_addr, ram_write, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/mem_arb_wait_counter.sv
// Counts consecutive cycles a pending loader request loses; raises ld_force at the limit.
module mem_arb_wait_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic ld_force
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (ld_gnt || !ld_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt < LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign ld_force = (wait_cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: fixed CPU priority, loader forced through after STARVE_LIMIT losses.
// Optional MEM_ARB_PERF_EN adds saturating stall / loader-grant counters.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = mem_pkg::ADDR_W,
  parameter int DATA_W       = mem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef MEM_ARB_PERF_EN
  output logic [15:0]           perf_stall_cnt,
  output logic [15:0]           perf_ld_gnt_cnt,
`endif
  mem_port_arbiter_if.slave     bus
);

  logic       cpu_req;
  logic       cpu_rd;
  logic       cpu_grant;
  logic       ld_req;
  logic       ld_grant;
  logic       ld_force;
  mem_owner_t rd_owner;
  mem_owner_t rd_owner_nxt;

  // Requests are masked while reset is high so every output sits at its reset value.
  assign cpu_rd    = !reset && (bus.cpu_mem_cmd == MREAD);
  assign cpu_req   = !reset && ((bus.cpu_mem_cmd == MREAD) || (bus.cpu_mem_cmd == MWRITE));
  assign ld_req    = !reset && bus.ld_req;
  assign ld_grant  = ld_req && (!cpu_req || ld_force);
  assign cpu_grant = cpu_req && !ld_grant;

  assign bus.cpu_stall = cpu_req && !cpu_grant;
  assign bus.ld_gnt    = ld_grant;

  mem_arb_wait_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .ld_req   (ld_req),
    .ld_gnt   (ld_grant),
    .ld_force (ld_force)
  );

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_din   = '0;
    bus.ram_write = 1'b0;
    if (ld_grant) begin
      bus.ram_addr  = bus.ld_addr;
      bus.ram_din   = bus.ld_wdata;
      bus.ram_write = bus.ld_we;
    end else if (cpu_grant) begin
      bus.ram_addr  = bus.cpu_mem_addr;
      bus.ram_din   = bus.cpu_wdata;
      bus.ram_write = (bus.cpu_mem_cmd == MWRITE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_nxt;
    end
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (cpu_grant && cpu_rd) begin
      rd_owner_nxt = OWN_CPU;
    end else if (ld_grant && !bus.ld_we) begin
      rd_owner_nxt = OWN_LD;
    end
  end

  // Response stage: RAM output steered to whichever side issued last cycle's read.
  assign bus.ld_rvalid     = (rd_owner == OWN_LD);
  assign bus.ld_rdata      = (rd_owner == OWN_LD)  ? bus.ram_dout : '0;
  assign bus.cpu_read_data = (rd_owner == OWN_CPU) ? bus.ram_dout : '0;

`ifdef MEM_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt  <= '0;
      perf_ld_gnt_cnt <= '0;
    end else begin
      if (bus.cpu_stall) perf_stall_cnt  <= sat_inc16(perf_stall_cnt);
      if (ld_grant)      perf_ld_gnt_cnt <= sat_inc16(perf_ld_gnt_cnt);
    end
  end
`endif

endmodule
